// File: rtl/sdram_bist.sv
`default_nettype none
// ============================================================================
// Module   : sdram_bist
// Purpose  : Built-in self test for an SDRAM controller. The test writes a
//            pattern to every word address from 0 to ADDR_LAST, reads each
//            word back, and compares it with the regenerated pattern. It
//            reports pass/fail, a saturating error count, the first failing
//            address and its read data, and a read-response timeout.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk_i          sole clock (also clocks the SDRAM controller)
//   resetn_i       asynchronous active-low reset
//   start_i        one-cycle pulse; begins a test when not running
//   mode_i         pattern select, sampled on start:
//                  0 fixed, 1 address-as-data, 2 LFSR, 3 inverted fixed
//   stop_on_err_i  end the test at the first mismatch, sampled on start
//   addr_o         controller word address
//   din_o          write data to the controller
//   dout_i         read data from the controller
//   wr_o / rd_o    one-cycle write / read command strobes
//   busy_i         controller busy level
//   data_ready_i   one-cycle read-data-valid
//   running_o      test in progress
//   done_o         test finished (held until the next start)
//   pass_o/fail_o  result, valid while done_o is high
//   timeout_o      a read never returned data
//   err_count_o    saturating mismatch count
//   fail_addr_o    address of the first mismatch
//   fail_data_o    read data of the first mismatch
// ============================================================================
module sdram_bist #(
   parameter int unsigned        ADDR_W    = 23,
   // Only 8 or 16 are legal data widths.
   parameter int unsigned        DATA_W    = 8,
   parameter logic [ADDR_W-1:0]  ADDR_LAST = '1,
   parameter logic [DATA_W-1:0]  PATTERN   = DATA_W'(8'h9C),
   parameter logic [15:0]        SEED      = 16'hACE1,
   parameter int unsigned        TIMEOUT   = 255
) (
   input  logic              clk_i,
   input  logic              resetn_i,
   input  logic              start_i,
   input  logic [1:0]        mode_i,
   input  logic              stop_on_err_i,
   output logic [ADDR_W-1:0] addr_o,
   output logic [DATA_W-1:0] din_o,
   input  logic [DATA_W-1:0] dout_i,
   output logic              wr_o,
   output logic              rd_o,
   input  logic              busy_i,
   input  logic              data_ready_i,
   output logic              running_o,
   output logic              done_o,
   output logic              pass_o,
   output logic              fail_o,
   output logic              timeout_o,
   output logic [15:0]       err_count_o,
   output logic [ADDR_W-1:0] fail_addr_o,
   output logic [DATA_W-1:0] fail_data_o
);

   localparam int unsigned        TMO_W    = $clog2(TIMEOUT + 1);
   localparam logic [TMO_W-1:0]   TMO_LAST = TMO_W'(TIMEOUT - 1);
   localparam int unsigned        AX_W     = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
   localparam logic [15:0]        LFSR_TAPS = 16'hB400;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      WR_ISSUE = 3'd1,
      WR_WAIT  = 3'd2,
      RD_ISSUE = 3'd3,
      RD_WAIT  = 3'd4,
      DONE     = 3'd5
   } state_t;

   state_t              state_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [DATA_W-1:0]   din_q;
   logic                wr_q;
   logic                rd_q;
   logic                running_q;
   logic                done_q;
   logic                pass_q;
   logic                fail_q;
   logic                timeout_q;
   logic [15:0]         err_count_q;
   logic [ADDR_W-1:0]   fail_addr_q;
   logic [DATA_W-1:0]   fail_data_q;
   logic [15:0]         lfsr_q;
   logic [1:0]          mode_q;
   logic                stop_q;
   logic                first_q;    // first WR_WAIT cycle: busy not yet raised
   logic                got_q;      // read data already received in RD_WAIT
   logic [TMO_W-1:0]    tmo_cnt_q;

   logic [15:0]         lfsr_step_d;
   logic [AX_W-1:0]     addr_ext_d;
   logic [DATA_W-1:0]   expect_d;
   logic [ADDR_W-1:0]   addr_inc_d;
   logic [15:0]         err_inc_d;
   logic [15:0]         err_after_d;
   logic                mismatch_d;
   logic                last_d;

   // Galois right-shift LFSR; stepped once per address advance in both
   // phases so the read phase regenerates the write-phase sequence.
   assign lfsr_step_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);

   // Widen the address so address-as-data zero-extends when ADDR_W < DATA_W.
   assign addr_ext_d  = AX_W'(addr_q);
   assign addr_inc_d  = addr_q + ADDR_W'(1);
   assign last_d      = (addr_q == ADDR_LAST);

   always_comb begin
      expect_d = PATTERN;
      unique case (mode_q)
         2'd0:    expect_d = PATTERN;
         2'd1:    expect_d = addr_ext_d[DATA_W-1:0];
         2'd2:    expect_d = lfsr_q[DATA_W-1:0];
         default: expect_d = ~PATTERN;
      endcase
   end

   // Only the first data_ready of a read is compared.
   assign mismatch_d  = data_ready_i && !got_q && (dout_i != expect_d);
   assign err_inc_d   = (err_count_q == 16'hFFFF) ? err_count_q : err_count_q + 16'd1;
   assign err_after_d = mismatch_d ? err_inc_d : err_count_q;

   always_ff @(posedge clk_i or negedge resetn_i) begin
      if (!resetn_i) begin
         state_q     <= IDLE;
         addr_q      <= '0;
         din_q       <= '0;
         wr_q        <= 1'b0;
         rd_q        <= 1'b0;
         running_q   <= 1'b0;
         done_q      <= 1'b0;
         pass_q      <= 1'b0;
         fail_q      <= 1'b0;
         timeout_q   <= 1'b0;
         err_count_q <= '0;
         fail_addr_q <= '0;
         fail_data_q <= '0;
         lfsr_q      <= SEED;
         mode_q      <= 2'd0;
         stop_q      <= 1'b0;
         first_q     <= 1'b0;
         got_q       <= 1'b0;
         tmo_cnt_q   <= '0;
      end else begin
         // Command strobes are single-cycle unless re-asserted below.
         wr_q <= 1'b0;
         rd_q <= 1'b0;

         unique case (state_q)
            IDLE, DONE: begin
               if (start_i) begin
                  err_count_q <= '0;
                  fail_addr_q <= '0;
                  fail_data_q <= '0;
                  done_q      <= 1'b0;
                  pass_q      <= 1'b0;
                  fail_q      <= 1'b0;
                  timeout_q   <= 1'b0;
                  addr_q      <= '0;
                  lfsr_q      <= SEED;
                  mode_q      <= mode_i;
                  stop_q      <= stop_on_err_i;
                  running_q   <= 1'b1;
                  state_q     <= WR_ISSUE;
               end
            end

            WR_ISSUE: begin
               if (!busy_i) begin
                  wr_q    <= 1'b1;
                  din_q   <= expect_d;
                  first_q <= 1'b1;
                  state_q <= WR_WAIT;
               end
            end

            WR_WAIT: begin
               // The controller raises busy one cycle after the strobe, so
               // the busy level seen on the first cycle is stale.
               if (first_q) begin
                  first_q <= 1'b0;
               end else if (!busy_i) begin
                  if (last_d) begin
                     addr_q  <= '0;
                     lfsr_q  <= SEED;
                     state_q <= RD_ISSUE;
                  end else begin
                     addr_q  <= addr_inc_d;
                     lfsr_q  <= lfsr_step_d;
                     state_q <= WR_ISSUE;
                  end
               end
            end

            RD_ISSUE: begin
               if (!busy_i) begin
                  rd_q      <= 1'b1;
                  got_q     <= 1'b0;
                  tmo_cnt_q <= '0;
                  state_q   <= RD_WAIT;
               end
            end

            RD_WAIT: begin
               if (mismatch_d) begin
                  err_count_q <= err_inc_d;
                  if (err_count_q == '0) begin
                     fail_addr_q <= addr_q;
                     fail_data_q <= dout_i;
                  end
               end
               if (data_ready_i) begin
                  got_q <= 1'b1;
               end

               if (!got_q && !data_ready_i) begin
                  // Counting starts on the rd strobe cycle, so timeout
                  // becomes visible exactly TIMEOUT cycles after rd.
                  if (tmo_cnt_q == TMO_LAST) begin
                     timeout_q   <= 1'b1;
                     err_count_q <= err_inc_d;
                     // fail_addr keeps first-failure meaning.
                     if (err_count_q == '0) begin
                        fail_addr_q <= addr_q;
                     end
                     running_q   <= 1'b0;
                     done_q      <= 1'b1;
                     pass_q      <= 1'b0;
                     fail_q      <= 1'b1;
                     state_q     <= DONE;
                  end else begin
                     tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
                  end
               end else if (mismatch_d && stop_q) begin
                  running_q <= 1'b0;
                  done_q    <= 1'b1;
                  pass_q    <= 1'b0;
                  fail_q    <= 1'b1;
                  state_q   <= DONE;
               end else if (!busy_i) begin
                  if (last_d) begin
                     running_q <= 1'b0;
                     done_q    <= 1'b1;
                     pass_q    <= (err_after_d == '0) && !timeout_q;
                     fail_q    <= !((err_after_d == '0) && !timeout_q);
                     state_q   <= DONE;
                  end else begin
                     addr_q  <= addr_inc_d;
                     lfsr_q  <= lfsr_step_d;
                     state_q <= RD_ISSUE;
                  end
               end
            end

            default: begin
               running_q <= 1'b0;
               state_q   <= IDLE;
            end
         endcase
      end
   end

   assign addr_o      = addr_q;
   assign din_o       = din_q;
   assign wr_o        = wr_q;
   assign rd_o        = rd_q;
   assign running_o   = running_q;
   assign done_o      = done_q;
   assign pass_o      = pass_q;
   assign fail_o      = fail_q;
   assign timeout_o   = timeout_q;
   assign err_count_o = err_count_q;
   assign fail_addr_o = fail_addr_q;
   assign fail_data_o = fail_data_q;

endmodule
`default_nettype wire

// File: tb/tb_sdram_bist.sv
`default_nettype none
// ============================================================================
// Module   : tb_sdram_bist
// Purpose  : Self-checking bench for sdram_bist with a behavioural SDRAM
//            controller model (memory array, busy and data_ready latencies,
//            bit-0 corruption at chosen addresses, non-responding address).
// Revision : 1.0 - initial release
// ============================================================================
module tb_sdram_bist;

   localparam int          AW      = 8;
   localparam int          DW      = 8;
   localparam int          LAST    = 15;
   localparam int          TMO     = 40;
   localparam logic [15:0] SEED_V  = 16'hACE1;

   logic          clk = 1'b0;
   logic          resetn = 1'b0;
   logic          start = 1'b0;
   logic [1:0]    mode = 2'd0;
   logic          stop_on_err = 1'b0;
   logic [AW-1:0] addr;
   logic [DW-1:0] din;
   logic [DW-1:0] dout = '0;
   logic          wr, rd, busy;
   logic          data_ready;
   logic          running, done, pass, fail, timeout;
   logic [15:0]   err_count;
   logic [AW-1:0] fail_addr;
   logic [DW-1:0] fail_data;

   sdram_bist #(
      .ADDR_W    (AW),
      .DATA_W    (DW),
      .ADDR_LAST (8'd15),
      .TIMEOUT   (TMO)
   ) dut (
      .clk_i         (clk),
      .resetn_i      (resetn),
      .start_i       (start),
      .mode_i        (mode),
      .stop_on_err_i (stop_on_err),
      .addr_o        (addr),
      .din_o         (din),
      .dout_i        (dout),
      .wr_o          (wr),
      .rd_o          (rd),
      .busy_i        (busy),
      .data_ready_i  (data_ready),
      .running_o     (running),
      .done_o        (done),
      .pass_o        (pass),
      .fail_o        (fail),
      .timeout_o     (timeout),
      .err_count_o   (err_count),
      .fail_addr_o   (fail_addr),
      .fail_data_o   (fail_data)
   );

   always #5 clk = ~clk;

   // ---------------- controller model ----------------
   logic [7:0]   mem [256];
   logic [255:0] corrupt_mask = '0;
   int           hang_addr = -1;
   bit           rand_lat = 1'b0;
   logic         force_busy = 1'b0;
   int           busy_cnt = 0;
   int           dr_cnt = 0;
   logic [7:0]   rd_data = '0;

   function automatic int pick_lat(input int dflt);
      return rand_lat ? int'($urandom_range(5, 1)) : dflt;
   endfunction

   assign busy = (busy_cnt != 0) || force_busy;

   always @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         busy_cnt   <= 0;
         dr_cnt     <= 0;
         data_ready <= 1'b0;
      end else begin
         data_ready <= 1'b0;
         if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
         if (dr_cnt != 0) begin
            dr_cnt <= dr_cnt - 1;
            if (dr_cnt == 1) begin
               data_ready <= 1'b1;
               dout       <= rd_data;
            end
         end
         if (wr) begin
            mem[addr] <= din;
            busy_cnt  <= pick_lat(2);
         end
         if (rd) begin
            rd_data  <= mem[addr] ^ {7'b0, corrupt_mask[addr]};
            busy_cnt <= pick_lat(3);
            if (int'(addr) != hang_addr) dr_cnt <= pick_lat(3);
         end
      end
   end

   // ---------------- reference model ----------------
   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string nm, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", nm, act, act, exp, exp, $time);
      end
   endtask

   function automatic logic [15:0] lfsr_next(input logic [15:0] x);
      int v;
      v = int'(x) / 2;
      if (x[0]) v = v ^ 'hB400;
      return 16'(v);
   endfunction

   function automatic logic [7:0] pat(input int m, input int a, input logic [15:0] lf);
      case (m)
         0:       return 8'h9C;
         1:       return 8'(a);
         2:       return lf[7:0];
         default: return 8'h63;
      endcase
   endfunction

   // Whole-test outcome derived from the test rules, address by address.
   task automatic ref_run(input int m, input bit stp, input logic [15:0] cm, input int hng,
                          output int n_rd, output int err, output int faddr, output int fdata,
                          output bit tmo, output bit ok);
      logic [15:0] lf;
      logic [7:0]  e;
      lf = SEED_V; err = 0; faddr = 0; fdata = 0; tmo = 0; n_rd = 0;
      for (int a = 0; a <= LAST; a++) begin
         e    = pat(m, a, lf);
         n_rd = a + 1;
         if (a == hng) begin
            if (err == 0) faddr = a;
            err++;
            tmo = 1;
            break;
         end
         if (cm[a]) begin
            if (err == 0) begin faddr = a; fdata = int'(e ^ 8'h01); end
            err++;
            if (stp) break;
         end
         lf = lfsr_next(lf);
      end
      ok = (err == 0) && !tmo;
   endtask

   // ---------------- run driver + monitor ----------------
   logic [7:0] exp_din [256];
   int         wr_idx, rd_idx;

   task automatic run_once(input int m, input bit stp, input logic [15:0] cm, input int hng,
                           input int hold_at, input bit repulse);
      logic [15:0] lf;
      int  hold_left, hold_wr, rd_hang_cyc;
      bit  held, tmo_seen, finished, prev_busy;
      corrupt_mask = '0;
      corrupt_mask[15:0] = cm;
      hang_addr = hng;
      lf = SEED_V;
      for (int a = 0; a <= LAST; a++) begin
         exp_din[a] = pat(m, a, lf);
         lf = lfsr_next(lf);
      end
      wr_idx = 0; rd_idx = 0;
      hold_left = 0; hold_wr = 0; rd_hang_cyc = 0;
      held = 0; tmo_seen = 0; finished = 0;
      @(negedge clk);
      mode = 2'(m); stop_on_err = stp; start = 1'b1;
      prev_busy = (busy_cnt != 0) || force_busy;
      for (int cyc = 0; cyc < 4000 && !finished; cyc++) begin
         @(negedge clk);
         start = (repulse && cyc == 25);
         mode = 2'($urandom); stop_on_err = 1'($urandom);
         if (wr) begin
            chk("wr_addr", int'(addr), wr_idx);
            chk("wr_din", int'(din), (wr_idx < 256) ? int'(exp_din[wr_idx]) : -1);
            chk("wr_while_busy", int'(prev_busy), 0);
            wr_idx++;
         end
         if (rd) begin
            chk("rd_addr", int'(addr), rd_idx);
            chk("rd_after_writes", wr_idx, LAST + 1);
            chk("rd_while_busy", int'(prev_busy), 0);
            if (rd_idx == hng) rd_hang_cyc = cyc;
            rd_idx++;
         end
         if (timeout && !tmo_seen) begin
            tmo_seen = 1;
            chk("timeout_latency", cyc - rd_hang_cyc, TMO);
         end
         if (done) finished = 1;
         else chk("running", int'(running), 1);
         if (hold_at >= 0 && !held && wr_idx == hold_at) begin
            force_busy = 1'b1; hold_left = 50; held = 1; hold_wr = wr_idx;
         end else if (hold_left > 0) begin
            hold_left--;
            if (hold_left == 0) begin
               force_busy = 1'b0;
               chk("no_wr_during_hold", wr_idx, hold_wr);
            end
         end
         prev_busy = (busy_cnt != 0) || force_busy;
      end
      start = 1'b0;
      force_busy = 1'b0;
      if (!finished) chk("done_within_bound", 0, 1);
   endtask

   task automatic check_result(input int e_err, input int e_faddr, input int e_fdata,
                               input bit e_pass, input bit e_tmo, input int e_rd);
      chk("done", int'(done), 1);
      chk("running_end", int'(running), 0);
      chk("pass", int'(pass), int'(e_pass));
      chk("fail", int'(fail), int'(!e_pass));
      chk("timeout", int'(timeout), int'(e_tmo));
      chk("err_count", int'(err_count), e_err);
      chk("fail_addr", int'(fail_addr), e_faddr);
      chk("fail_data", int'(fail_data), e_fdata);
      chk("wr_count", wr_idx, LAST + 1);
      chk("rd_count", rd_idx, e_rd);
   endtask

   typedef struct {
      int          mode;
      bit          stop;
      logic [15:0] cmask;
      int          hang;
      int          e_err;
      int          e_faddr;
      bit          e_pass;
      bit          e_tmo;
      int          e_rd;
   } vec_t;

   vec_t vt [7];

   initial begin
      int  r_rd, r_err, r_fa, r_fd, nrd;
      bit  r_tmo, r_ok;
      vec_t v;

      vt[0] = '{0, 1'b0, 16'h0000, -1, 0, 0, 1'b1, 1'b0, 16};
      vt[1] = '{2, 1'b0, 16'h0220, -1, 2, 5, 1'b0, 1'b0, 16};
      vt[2] = '{2, 1'b1, 16'h0220, -1, 1, 5, 1'b0, 1'b0, 6};
      vt[3] = '{0, 1'b0, 16'h0000,  3, 1, 3, 1'b0, 1'b1, 4};
      vt[4] = '{1, 1'b0, 16'h0000, -1, 0, 0, 1'b1, 1'b0, 16};
      vt[5] = '{3, 1'b0, 16'h8001, -1, 2, 0, 1'b0, 1'b0, 16};
      vt[6] = '{1, 1'b1, 16'h8000, -1, 1, 15, 1'b0, 1'b0, 16};

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_wr", int'(wr), 0);
      chk("rst_rd", int'(rd), 0);
      chk("rst_addr", int'(addr), 0);
      chk("rst_din", int'(din), 0);
      chk("rst_status", int'({running, done, pass, fail, timeout}), 0);
      chk("rst_err_count", int'(err_count), 0);
      chk("rst_fail_addr", int'(fail_addr), 0);
      chk("rst_fail_data", int'(fail_data), 0);
      resetn = 1'b1;
      repeat (2) @(negedge clk);
      chk("idle_not_running", int'(running), 0);

      // Table-driven directed runs
      for (int i = 0; i < 7; i++) begin
         v = vt[i];
         ref_run(v.mode, v.stop, v.cmask, v.hang, r_rd, r_err, r_fa, r_fd, r_tmo, r_ok);
         run_once(v.mode, v.stop, v.cmask, v.hang, -1, 1'b0);
         check_result(v.e_err, v.e_faddr, r_fd, v.e_pass, v.e_tmo, v.e_rd);
      end

      // Busy held 50 cycles mid write phase, plus a start pulse while running
      run_once(0, 1'b0, 16'h0000, -1, 7, 1'b1);
      check_result(0, 0, 0, 1'b1, 1'b0, 16);

      // Reset while in RD_WAIT: strobes and status drop immediately
      corrupt_mask = '0; hang_addr = -1;
      @(negedge clk);
      mode = 2'd0; stop_on_err = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      nrd = 0;
      for (int c = 0; c < 2000 && nrd < 3; c++) begin
         @(negedge clk);
         if (rd) nrd++;
      end
      chk("reached_rd_wait", nrd, 3);
      #2 resetn = 1'b0;
      #1;
      chk("async_rst_rd", int'(rd), 0);
      chk("async_rst_wr", int'(wr), 0);
      chk("async_rst_running", int'(running), 0);
      chk("async_rst_done", int'(done), 0);
      chk("async_rst_addr", int'(addr), 0);
      @(negedge clk);
      resetn = 1'b1;
      run_once(0, 1'b0, 16'h0000, -1, -1, 1'b0);
      check_result(0, 0, 0, 1'b1, 1'b0, 16);

      // Randomized runs against the reference model
      rand_lat = 1'b1;
      for (int i = 0; i < 8; i++) begin
         int          m, h;
         bit          s;
         logic [15:0] cm;
         m  = int'($urandom_range(3, 0));
         s  = 1'($urandom);
         cm = 16'($urandom & $urandom & $urandom);
         h  = ($urandom_range(3, 0) == 0) ? int'($urandom_range(LAST, 0)) : -1;
         ref_run(m, s, cm, h, r_rd, r_err, r_fa, r_fd, r_tmo, r_ok);
         run_once(m, s, cm, h, -1, 1'b0);
         check_result(r_err, r_fa, r_fd, r_ok, r_tmo, r_rd);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
